rr_arb_ctrl: RTL and testbench

Sequential round-robin arbiter controller that shares one downstream resource among `ARB_WIDTH` requesters with multi-cycle grant ownership. It registers the grant, holds it until the owner signals completion, and rotates a one-hot priority pointer. Internally it uses the team's combinational parallel-prefix round-robin arbitration: the priority index wins first, then the search proceeds circularly upward. It sits between requester ports and a shared bus or datapath and replaces ad-hoc priority handling at each integration point.

---
 rtl/rr_arb_ctrl.sv | 157 +++++++++++++++
 tb/tb_rr_arb_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/rr_arb_ctrl.sv
// Round-robin arbiter controller with registered one-hot grant, multi-cycle ownership and rotating priority.
// Optional forced release after MAX_HOLD busy cycles is built when ARB_TIMEOUT_EN is defined.
//
// state  | meaning
// S_IDLE | no owner, o_grant is zero; arbitrates on any nonzero i_req
// S_BUSY | one owner holds o_grant until its i_done bit (or a forced release)
module rr_arb_ctrl #(
    parameter int ARB_WIDTH = 8,
    parameter int ID_W      = 3,
    parameter int MAX_HOLD  = 255
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [ARB_WIDTH-1:0] i_req,
    input  logic [ARB_WIDTH-1:0] i_done,
    output logic [ARB_WIDTH-1:0] o_grant,
    output logic [ID_W-1:0]      o_grant_id,
    output logic                 o_ag,
    output logic [ARB_WIDTH-1:0] o_prior,
    output logic                 o_timeout
);

    if (ARB_WIDTH < 2 || ARB_WIDTH > 32 || (ARB_WIDTH & (ARB_WIDTH - 1)) != 0) begin : g_bad_width
        $error("rr_arb_ctrl: ARB_WIDTH must be a power of two in 2..32");
    end
    if (ID_W != $clog2(ARB_WIDTH)) begin : g_bad_id_w
        $error("rr_arb_ctrl: ID_W must equal log2(ARB_WIDTH)");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > 65535) begin : g_bad_hold
        $error("rr_arb_ctrl: MAX_HOLD must be in 1..65535");
    end

    localparam logic [ARB_WIDTH-1:0] ONE = ARB_WIDTH'(1);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t               state, state_n;
    logic [ARB_WIDTH-1:0] grant_q, grant_n;
    logic [ID_W-1:0]      grant_id_q, grant_id_n;
    logic                 ag_q, ag_n;
    logic [ARB_WIDTH-1:0] prior_q, prior_n;
    logic                 done_hit;
    logic                 expire;
    logic                 release_now;
    logic [ARB_WIDTH-1:0] prior_rot;

    // Winner is the lowest set request at or above the pointer; otherwise wrap to the lowest set request.
    function automatic logic [ARB_WIDTH-1:0] rr_pick(input logic [ARB_WIDTH-1:0] req,
                                                     input logic [ARB_WIDTH-1:0] prior);
        logic [ARB_WIDTH-1:0] upper;
        upper = req & ~(prior - ONE);
        if (|upper) begin
            return upper & (~upper + ONE);
        end
        return req & (~req + ONE);
    endfunction

    function automatic logic [ID_W-1:0] onehot_to_bin(input logic [ARB_WIDTH-1:0] v);
        logic [ID_W-1:0] id;
        id = '0;
        for (int i = 0; i < ARB_WIDTH; i++) begin
            if (v[i]) begin
                id = id | ID_W'(i);
            end
        end
        return id;
    endfunction

    assign done_hit    = |(i_done & grant_q);
    assign release_now = (state == S_BUSY) && (done_hit || expire);
    assign prior_rot   = {grant_q[ARB_WIDTH-2:0], grant_q[ARB_WIDTH-1]};

    always_comb begin
        state_n = state;
        grant_n = grant_q;
        prior_n = prior_q;
        case (state)
            S_IDLE: begin
                if (|i_req) begin
                    grant_n = rr_pick(i_req, prior_q);
                    state_n = S_BUSY;
                end
            end
            S_BUSY: begin
                if (release_now) begin
                    prior_n = prior_rot;
                    grant_n = rr_pick(i_req, prior_rot);
                    state_n = (|grant_n) ? S_BUSY : S_IDLE;
                end
            end
            default: begin
                state_n = S_IDLE;
                grant_n = '0;
            end
        endcase
        grant_id_n = onehot_to_bin(grant_n);
        ag_n       = |grant_n;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= S_IDLE;
            grant_q    <= '0;
            grant_id_q <= '0;
            ag_q       <= 1'b0;
            prior_q    <= ONE;
        end else begin
            state      <= state_n;
            grant_q    <= grant_n;
            grant_id_q <= grant_id_n;
            ag_q       <= ag_n;
            prior_q    <= prior_n;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam logic [15:0] HOLD_LAST = 16'(MAX_HOLD - 1);

    logic [15:0] hold_cnt, hold_cnt_n;
    logic        timeout_q, timeout_n;

    // Expire on the edge that closes the MAX_HOLD-th busy cycle.
    assign expire = (hold_cnt == HOLD_LAST);

    always_comb begin
        hold_cnt_n = hold_cnt + 16'd1;
        if (state == S_IDLE || release_now) begin
            hold_cnt_n = '0;
        end
        timeout_n = release_now && expire && !done_hit;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            hold_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_cnt  <= hold_cnt_n;
            timeout_q <= timeout_n;
        end
    end

    assign o_timeout = timeout_q;
`else
    assign expire    = 1'b0;
    assign o_timeout = 1'b0;
`endif

    assign o_grant    = grant_q;
    assign o_grant_id = grant_id_q;
    assign o_ag       = ag_q;
    assign o_prior    = prior_q;

endmodule

// File: tb/tb_rr_arb_ctrl.sv
// Scoreboard bench for rr_arb_ctrl: directed vectors push expected outputs, a monitor pops and compares each cycle.
// The forced-release scenario runs only when ARB_TIMEOUT_EN is defined (MAX_HOLD=4 then).
module tb_rr_arb_ctrl;

`ifdef ARB_TIMEOUT_EN
    localparam int TB_HOLD = 4;
`else
    localparam int TB_HOLD = 255;
`endif

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic [7:0] done;
    logic [7:0] grant;
    logic [2:0] grant_id;
    logic       ag;
    logic [7:0] prior;
    logic       timeout;

    typedef struct packed {
        logic [7:0] grant;
        logic [2:0] id;
        logic       ag;
        logic [7:0] prior;
        logic       to;
    } exp_t;

    exp_t exp_q[$];
    int   tag_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step_no  = 0;
    bit   stim_done = 0;

    rr_arb_ctrl #(.ARB_WIDTH(8), .ID_W(3), .MAX_HOLD(TB_HOLD)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_req      (req),
        .i_done     (done),
        .o_grant    (grant),
        .o_grant_id (grant_id),
        .o_ag       (ag),
        .o_prior    (prior),
        .o_timeout  (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] bin_of(input logic [7:0] v);
        logic [2:0] id;
        id = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) id = 3'(i);
        end
        return id;
    endfunction

    // Drive one cycle of inputs and queue what must be visible after the following rising edge.
    task automatic step(input logic r, input logic [7:0] rq, input logic [7:0] dn,
                        input logic [7:0] eg, input logic [7:0] ep, input logic et);
        exp_t e;
        @(negedge clk);
        rst  = r;
        req  = rq;
        done = dn;
        e.grant = eg;
        e.id    = bin_of(eg);
        e.ag    = |eg;
        e.prior = ep;
        e.to    = et;
        step_no++;
        exp_q.push_back(e);
        tag_q.push_back(step_no);
    endtask

    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            exp_t a;
            int   t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = '{grant: grant, id: grant_id, ag: ag, prior: prior, to: timeout};
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL step_%0d got grant=%h id=%0d ag=%b prior=%h to=%b required grant=%h id=%0d ag=%b prior=%h to=%b",
                         t, a.grant, a.id, a.ag, a.prior, a.to, e.grant, e.id, e.ag, e.prior, e.to);
            end
        end
    end

    initial begin
        rst  = 1'b1;
        req  = 8'h00;
        done = 8'h00;

        // reset values, then single requester 0
        step(1, 8'h00, 8'h00, 8'h00, 8'h01, 0);
        step(1, 8'h00, 8'h00, 8'h00, 8'h01, 0);
        step(0, 8'h01, 8'h00, 8'h01, 8'h01, 0);
        step(0, 8'h00, 8'h01, 8'h00, 8'h02, 0);
        step(0, 8'h00, 8'h00, 8'h00, 8'h02, 0);

        // all requesting: 0,1,...,7,0 with no bubble
        step(1, 8'h00, 8'h00, 8'h00, 8'h01, 0);
        step(0, 8'hFF, 8'h00, 8'h01, 8'h01, 0);
        for (int k = 0; k < 8; k++) begin
            step(0, 8'hFF, 8'(1 << k), 8'(1 << ((k + 1) % 8)), 8'(1 << ((k + 1) % 8)), 0);
        end
        step(0, 8'h00, 8'h01, 8'h00, 8'h02, 0);

        // sole requester 3 re-granted on its own release
        step(1, 8'h00, 8'h00, 8'h00, 8'h01, 0);
        step(0, 8'h08, 8'h00, 8'h08, 8'h01, 0);
        step(0, 8'h08, 8'h08, 8'h08, 8'h10, 0);
        step(0, 8'h00, 8'h08, 8'h00, 8'h10, 0);

        // owner 5 ignores foreign done and its own request drop
        step(0, 8'h20, 8'h00, 8'h20, 8'h10, 0);
        step(0, 8'h20, 8'h04, 8'h20, 8'h10, 0);
        step(0, 8'h00, 8'h00, 8'h20, 8'h10, 0);
        step(0, 8'h00, 8'h00, 8'h20, 8'h10, 0);
        step(0, 8'h00, 8'h20, 8'h00, 8'h40, 0);

        // circular search across the wrap point
        step(0, 8'h81, 8'h00, 8'h80, 8'h40, 0);
        step(0, 8'h81, 8'h80, 8'h01, 8'h01, 0);
        step(0, 8'h81, 8'h01, 8'h80, 8'h02, 0);

        // reset while owner 6 holds the grant
        step(0, 8'h40, 8'h80, 8'h40, 8'h01, 0);
        step(0, 8'h40, 8'h00, 8'h40, 8'h01, 0);
        step(1, 8'h40, 8'h00, 8'h00, 8'h01, 0);
        step(0, 8'h00, 8'h00, 8'h00, 8'h01, 0);

`ifdef ARB_TIMEOUT_EN
        // owner 1 never finishes: forced release after 4 busy cycles hands over to 2
        step(0, 8'h02, 8'h00, 8'h02, 8'h01, 0);
        step(0, 8'h06, 8'h00, 8'h02, 8'h01, 0);
        step(0, 8'h06, 8'h00, 8'h02, 8'h01, 0);
        step(0, 8'h06, 8'h00, 8'h02, 8'h01, 0);
        step(0, 8'h06, 8'h00, 8'h04, 8'h04, 1);
        step(0, 8'h00, 8'h00, 8'h04, 8'h04, 0);
        step(0, 8'h00, 8'h04, 8'h00, 8'h08, 0);
`else
        // without the timeout the owner keeps the grant
        step(0, 8'h02, 8'h00, 8'h02, 8'h01, 0);
        for (int k = 0; k < 10; k++) begin
            step(0, 8'h06, 8'h00, 8'h02, 8'h01, 0);
        end
        step(0, 8'h06, 8'h02, 8'h04, 8'h04, 0);
        step(0, 8'h00, 8'h04, 8'h00, 8'h08, 0);
`endif

        @(negedge clk);
        req  = 8'h00;
        done = 8'h00;
        @(negedge clk);
        @(negedge clk);
        stim_done = 1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL queue_drained got %0d entries left required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        if (!stim_done) begin
            $display("FAIL watchdog got timeout required finish");
            $fatal(1, "watchdog");
        end
    end

endmodule
